// File: rtl/multiply_add_pkg.sv
// Shared constants for the board arithmetic blocks (divider and multiply_add):
// FSM state encodings, operand entry-slot indices and the default operand width.
package multiply_add_pkg;

  localparam int W_DEFAULT = 8;   // default operand / LED width
  localparam int NIB_W     = 4;   // bits captured from sw per press
  localparam int OPERANDS  = 3;   // q, d, r are keyed in, in that order

  // Operand slot order during entry (MSB nibble of each operand first)
  localparam int SLOT_Q = 0;
  localparam int SLOT_D = 1;
  localparam int SLOT_R = 2;

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Button presses needed to key in one operand of width w
  function automatic int nib_per_op(input int w);
    return w / NIB_W;
  endfunction

endpackage

// File: rtl/debounce.sv
// Push-button debouncer: two-flop synchroniser, then the output follows the
// synchronised input only after it has held a new level for STABLE clocks.
// Carries no reset: it settles to the button level within a few clocks.
module debounce #(
  parameter int STABLE = 2
) (
  input  logic pb_1,
  input  logic clk,
  output logic pb_out
);

  localparam int CNT_W = $clog2(STABLE) + 1;

  logic             sync1_reg;
  logic             sync2_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             pb_out_reg;

  // Synchronise the raw button and accept a new level once it has been stable
  always_ff @(posedge clk) begin
    sync1_reg <= pb_1;
    sync2_reg <= sync1_reg;
    if (sync2_reg == pb_out_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg >= CNT_W'(STABLE - 1)) begin
      pb_out_reg <= sync2_reg;
      cnt_reg    <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign pb_out = pb_out_reg;

endmodule

// File: rtl/shift_add_mul.sv
// Sequential shift-and-add multiplier producing acc = q*d + r.
// start loads the operands (acc preloaded with r); W iterations follow.
// done is high during the final iteration cycle so the owner can change
// state on the same edge that retires the last partial product.
module shift_add_mul
  import multiply_add_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           clear,
  input  logic [W-1:0]   q,
  input  logic [W-1:0]   d,
  input  logic [W-1:0]   r,
  output logic [2*W-1:0] acc,
  output logic           done
);

  localparam int IT_W = $clog2(W);

  logic [2*W-1:0] acc_reg;
  logic [2*W-1:0] mcand_reg;
  logic [W-1:0]   mplier_reg;
  logic [IT_W-1:0] iter_reg;
  logic           run_reg;

  assign done = run_reg && (iter_reg == IT_W'(W - 1));
  assign acc  = acc_reg;

  // Load on start, then one multiplier bit per clock, LSB first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      iter_reg   <= '0;
      run_reg    <= 1'b0;
    end else if (start) begin
      acc_reg    <= {{W{1'b0}}, r};
      mcand_reg  <= {{W{1'b0}}, d};
      mplier_reg <= q;
      iter_reg   <= '0;
      run_reg    <= 1'b1;
    end else if (clear) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      iter_reg   <= '0;
      run_reg    <= 1'b0;
    end else if (run_reg) begin
      if (mplier_reg[0]) begin
        acc_reg <= acc_reg + mcand_reg;
      end
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      iter_reg   <= iter_reg + IT_W'(1);
      if (done) begin
        run_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multiply_add.sv
// Board block rebuilding dividend = q*d + r from keyed-in nibbles.
// Entry order q, d, r, MSB nibble first; result shown high half then low half.
// Optional build macro MULT_ADD_CHECK_EN adds the err port (r >= d in DONE).
module multiply_add
  import multiply_add_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   sw,
  input  logic         btn,
  output logic [W-1:0] led,
  output logic         busy
`ifdef MULT_ADD_CHECK_EN
  ,
  output logic         err
`endif
);

  localparam int NIB_PER_OP = nib_per_op(W);
  localparam int NUM_SLOTS  = OPERANDS * NIB_PER_OP;
  localparam int CNT_W      = $clog2(NUM_SLOTS);
  localparam int ENT_W      = OPERANDS * W;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] slot_reg, slot_next;
  logic             phase_reg, phase_next;
  logic [ENT_W-1:0] entry_reg, entry_next;
  logic             pb_out;
  logic             pb_prev_reg;
  logic             press_pulse;
  logic             wr_en;
  logic             mul_start;
  logic             mul_clear;
  logic             mul_done;
  logic [2*W-1:0]   acc;

  debounce u_debounce (
    .pb_1   (btn),
    .clk    (clk),
    .pb_out (pb_out)
  );

  // Rising-edge detector: one single-cycle pulse per debounced press
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pb_prev_reg <= 1'b0;
    else        pb_prev_reg <= pb_out;
  end

  assign press_pulse = pb_out && !pb_prev_reg;
  assign wr_en       = press_pulse && (state_reg == ST_ENTRY);

  // Each slot owns one nibble of the q|d|r entry vector, MSB nibble first
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    assign entry_next[ENT_W-1-NIB_W*gi -: NIB_W] =
      (wr_en && slot_reg == CNT_W'(gi)) ? sw : entry_reg[ENT_W-1-NIB_W*gi -: NIB_W];
  end

  // Entry operand storage, wiped when the user leaves DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         entry_reg <= '0;
    else if (mul_clear) entry_reg <= '0;
    else                entry_reg <= entry_next;
  end

  // The multiplier is fed from entry_next so the final nibble is included
  // on the same edge that starts it
  shift_add_mul #(.W(W)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .clear (mul_clear),
    .q     (entry_next[(OPERANDS-1-SLOT_Q)*W +: W]),
    .d     (entry_next[(OPERANDS-1-SLOT_D)*W +: W]),
    .r     (entry_next[(OPERANDS-1-SLOT_R)*W +: W]),
    .acc   (acc),
    .done  (mul_done)
  );

  // FSM state, entry slot counter and display phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_ENTRY;
      slot_reg  <= '0;
      phase_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
      phase_reg <= phase_next;
    end
  end

  // Next-state logic; presses while BUSY are simply not looked at
  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    phase_next = phase_reg;
    mul_start  = 1'b0;
    mul_clear  = 1'b0;
    case (state_reg)
      ST_ENTRY: begin
        if (wr_en) begin
          if (slot_reg == CNT_W'(NUM_SLOTS - 1)) begin
            slot_next  = '0;
            state_next = ST_BUSY;
            mul_start  = 1'b1;
          end else begin
            slot_next = slot_reg + CNT_W'(1);
          end
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          state_next = ST_DONE;
          phase_next = 1'b0;
        end
      end
      ST_DONE: begin
        if (press_pulse) begin
          if (!phase_reg) begin
            phase_next = 1'b1;
          end else begin
            state_next = ST_ENTRY;
            phase_next = 1'b0;
            mul_clear  = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_ENTRY;
        slot_next  = '0;
        phase_next = 1'b0;
      end
    endcase
  end

  // Display: dark during entry and while iterating, result halves in DONE
  always_comb begin
    led  = '0;
    busy = (state_reg == ST_BUSY);
    if (state_reg == ST_DONE) begin
      led = phase_reg ? acc[W-1:0] : acc[2*W-1:W];
    end
  end

`ifdef MULT_ADD_CHECK_EN
  logic err_reg;

  // Flag an illegal remainder (r >= d, which includes d = 0) while in DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_reg <= 1'b0;
    end else if (state_reg == ST_BUSY && mul_done) begin
      err_reg <= (entry_reg[(OPERANDS-1-SLOT_R)*W +: W] >=
                  entry_reg[(OPERANDS-1-SLOT_D)*W +: W]);
    end else if (mul_clear) begin
      err_reg <= 1'b0;
    end
  end

  assign err = err_reg;
`endif

endmodule

// File: tb/tb_multiply_add.sv
// Directed bench for multiply_add: keys operands in through the button,
// queues q*d+r when entry completes and checks it when DONE is reached.
module tb_multiply_add;
  import multiply_add_pkg::*;

  localparam int W  = W_DEFAULT;
  localparam int NS = 3 * (W / 4);

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         btn   = 1'b0;
  logic [3:0]   sw    = 4'h0;
  logic [W-1:0] led;
  logic         busy;
`ifdef MULT_ADD_CHECK_EN
  logic         err;
`endif

  typedef struct packed {
    logic [2*W-1:0] res;
    logic           e;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  multiply_add #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw),
    .btn   (btn),
    .led   (led),
    .busy  (busy)
`ifdef MULT_ADD_CHECK_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] nib);
    sw  = nib;
    btn = 1'b1;
    repeat (8) tick();
    btn = 1'b0;
    repeat (8) tick();
  endtask

  // mode 0: plain entry; 1: extra press while BUSY; 2: reset mid-BUSY
  task automatic enter(input logic [W-1:0] q, input logic [W-1:0] d,
                       input logic [W-1:0] r, input int mode);
    logic [3*W-1:0] v;
    exp_t           e;
    int             c;
    v     = {q, d, r};
    e.res = (2*W)'(q) * (2*W)'(d) + (2*W)'(r);
    e.e   = (r >= d);
    sb.push_back(e);
    for (int i = 0; i < NS - 1; i++) press(v[3*W-1-4*i -: 4]);
    sw  = v[3:0];
    btn = 1'b1;
    c   = 0;
    while (!busy && c < 40) begin tick(); c++; end
    check("busy_rise", busy, 1);
    check("led_busy", led, 0);
    if (mode == 2) begin
      repeat (3) tick();
      #3 reset = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_led", led, 0);
`ifdef MULT_ADD_CHECK_EN
      check("rst_err", err, 0);
`endif
      void'(sb.pop_back());
      btn = 1'b0;
      repeat (10) tick();
      reset = 1'b1;
      tick();
      $display("txn abort q=%h d=%h r=%h", q, d, r);
    end else begin
      c = 0;
      if (mode == 1) begin
        btn = 1'b0;
        tick(); tick();
        c = 2;
        btn = 1'b1;
      end
      while (busy && c < 40) begin tick(); c++; end
      check("busy_cycles", c, W);
      btn = 1'b0;
      repeat (8) tick();
    end
  endtask

  task automatic check_done(input string tag);
    exp_t e;
    check({tag, "_sb"}, (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_hi"}, led, e.res[2*W-1:W]);
`ifdef MULT_ADD_CHECK_EN
      check({tag, "_err"}, err, e.e);
`endif
      press(4'h0);
      check({tag, "_lo"}, led, e.res[W-1:0]);
      check({tag, "_busy"}, busy, 0);
`ifdef MULT_ADD_CHECK_EN
      check({tag, "_err1"}, err, e.e);
`endif
      press(4'h0);
      check({tag, "_clr"}, led, 0);
`ifdef MULT_ADD_CHECK_EN
      check({tag, "_errclr"}, err, 0);
`endif
      $display("txn %s result=%h err=%0b", tag, e.res, e.e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (20) tick();
    check("reset_led", led, 0);
    check("reset_busy", busy, 0);
`ifdef MULT_ADD_CHECK_EN
    check("reset_err", err, 0);
`endif
    reset = 1'b1;
    repeat (4) tick();

    enter(8'h0D, 8'h07, 8'h03, 0);   // 13*7+3 = 0x005E
    check_done("t1");
    enter(8'hFF, 8'hFF, 8'hFF, 0);   // 0xFF00
    check_done("t2");
    enter(8'h00, 8'h00, 8'h42, 0);   // q=d=0 -> r
    check_done("t3");
    enter(8'h21, 8'h05, 8'h01, 1);   // press lands mid-BUSY
    check_done("t4");
    enter(8'hA5, 8'h3C, 8'h11, 2);   // reset mid-BUSY
    enter(8'h12, 8'h34, 8'h56, 0);   // fresh entry after reset
    check_done("t5");

    // reset while showing a result
    enter(8'h80, 8'h02, 8'h00, 0);
    check("t5b_pre", led, 8'h01);
    #3 reset = 1'b0;
    #1;
    check("t5b_led", led, 0);
    void'(sb.pop_front());
    repeat (4) tick();
    reset = 1'b1;
    tick();

    enter(8'h03, 8'h07, 8'h09, 0);   // 0x1E, r>=d
    check_done("t6a");
    enter(8'h03, 8'h07, 8'h06, 0);   // 0x1B, legal remainder
    check_done("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
